// File: rtl/flag_pkg.sv
// Shared definitions for the ALU status-flag unit and its branch-condition users.
package flag_pkg;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   typedef logic [3:0] flags_t;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'd0,
      COND_Z      = 3'd1,
      COND_NZ     = 3'd2,
      COND_N      = 3'd3,
      COND_NN     = 3'd4,
      COND_C      = 3'd5,
      COND_NC     = 3'd6,
      COND_V      = 3'd7
   } cond_e;

endpackage

// File: rtl/flag_cond_mux.sv
// Combinational branch-condition selector over a {V,C,N,Z} flag vector.
module flag_cond_mux
   import flag_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [2:0] cond_sel,
   output logic       result
);

   always_comb begin
      result = 1'b0;
      case (cond_e'(cond_sel))
         COND_ALWAYS: result = 1'b1;
         COND_Z:      result = flags[FLAG_Z];
         COND_NZ:     result = ~flags[FLAG_Z];
         COND_N:      result = flags[FLAG_N];
         COND_NN:     result = ~flags[FLAG_N];
         COND_C:      result = flags[FLAG_C];
         COND_NC:     result = ~flags[FLAG_C];
         COND_V:      result = flags[FLAG_V];
         default:     result = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_unit.sv
// ALU status-flag register with sticky overflow, saturating zero counter and
// registered branch-condition evaluation.
module flag_unit
   import flag_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ZCNT_W   = 8,
   parameter int STICKY_V = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              ALU_EN,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_ovf,
   input  logic              CLR,
   input  logic              OUT_EN,
   input  logic [2:0]        cond_sel,
   output logic              out,
   output logic              out_valid,
   output logic [3:0]        flags,
   output logic [ZCNT_W-1:0] zero_cnt
);

   flags_t            flags_q;
   flags_t            cap_flags;
   flags_t            flags_nxt;
   flags_t            eval_flags;
   logic [ZCNT_W-1:0] zcnt_q;
   logic              z_new;
   logic              cond_res;

   assign z_new = (alu_result == '0);

   // CLR in the capture cycle drops the sticky history so V follows alu_ovf only.
   always_comb begin
      cap_flags         = '0;
      cap_flags[FLAG_Z] = z_new;
      cap_flags[FLAG_N] = alu_result[DATA_W-1];
      cap_flags[FLAG_C] = alu_carry;
      cap_flags[FLAG_V] = alu_ovf | ((STICKY_V != 0) & flags_q[FLAG_V] & ~CLR);
   end

   always_comb begin
      flags_nxt = flags_q;
      if (ALU_EN)
         flags_nxt = cap_flags;
      else if (CLR)
         flags_nxt = '0;
   end

   // A pure CLR never forwards: the condition still sees the pre-clear flags.
   assign eval_flags = ((BYPASS != 0) && ALU_EN) ? cap_flags : flags_q;

   flag_cond_mux u_cond (
      .flags    (eval_flags),
      .cond_sel (cond_sel),
      .result   (cond_res)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         flags_q   <= '0;
         zcnt_q    <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         flags_q <= flags_nxt;

         if (CLR)
            zcnt_q <= (ALU_EN && z_new) ? ZCNT_W'(1) : '0;
         else if (ALU_EN && z_new && (zcnt_q != '1))
            zcnt_q <= zcnt_q + ZCNT_W'(1);

         out_valid <= OUT_EN;
         if (OUT_EN)
            out <= cond_res;
      end
   end

   assign flags    = flags_q;
   assign zero_cnt = zcnt_q;

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised ALU status-flag unit for the downsampling processor datapath; successor to the single-bit zero-flag register.
- Captures Zero, Negative, Carry and Overflow from a DATA_W-bit ALU result, with an optionally sticky Overflow flag.
- Evaluates a controller-selected branch condition and returns a registered 1-bit answer with a valid pulse.
- Keeps a saturating count of zero results for loop-termination checks.
- Sits between the ALU output and the controller's branch logic.

## Interface
Parameters:
- DATA_W, 16: ALU result width (≥2).
- ZCNT_W, 8: width of the zero-result counter.
- STICKY_V, 1: 1 = Overflow accumulates until CLR; 0 = Overflow reflects the last capture only.
- BYPASS, 1: 1 = a condition requested in the same cycle as a capture uses the new flags; 0 = it uses the old flags.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ALU_EN  in  1  capture flags from this cycle's ALU outputs.
- alu_result  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry-out.
- alu_ovf  in  1  ALU signed overflow.
- CLR  in  1  synchronous clear of flags, sticky history and zero counter.
- OUT_EN  in  1  controller request to evaluate a condition.
- cond_sel  in  3  condition code; sampled with OUT_EN.
- out  out  1  registered condition result.
- out_valid  out  1  one-cycle pulse, high the cycle after an accepted OUT_EN.
- flags  out  4  current flag register {V,C,N,Z}; Z is bit 0.
- zero_cnt  out  ZCNT_W  saturating count of captures with Z=1.

## Operation
Capture values, computed combinationally from inputs:
- Z_new = (alu_result == 0)
- N_new = alu_result[DATA_W-1]
- C_new = alu_carry
- V_new = alu_ovf | (STICKY_V & V_cur & ~CLR)

Flag update priority, per edge:
- RST: all state forced to 0.
- ALU_EN=1: flags ← new values. This applies even if CLR=1; in that case the sticky history is dropped, so V = alu_ovf.
- CLR=1 with ALU_EN=0: flags ← 0.
- Neither: flags hold.

Zero counter:
- CLR=1 sets it to 0. If ALU_EN=1 and Z_new=1 in the same cycle, it is set to 1 instead.
- Otherwise, ALU_EN=1 with Z_new=1 increments it, saturating at 2^ZCNT_W−1 (no wrap).

Condition codes on cond_sel:
- 0: always 1.
- 1: Z.
- 2: !Z.
- 3: N.
- 4: !N.
- 5: C.
- 6: !C.
- 7: V.

Evaluation:
- The source flags are the next-state flags when BYPASS=1 and ALU_EN=1; the current flags otherwise.
- With BYPASS=1, a simultaneous CLR and ALU_EN evaluates against the new values.
- With BYPASS=1, CLR alone still evaluates against the current (pre-clear) flags.

Output handshake:
- OUT_EN=1: out ← result, out_valid ← 1.
- OUT_EN=0: out holds its last value, out_valid ← 0.
- Back-to-back OUT_EN is accepted every cycle; there is no stall and no backpressure.

## Timing
- Capture latency: 1 cycle. Flags and zero_cnt reflect ALU_EN inputs after the next rising edge.
- Condition latency: 1 cycle. out and out_valid are valid the cycle after OUT_EN.
- Reset values: flags=4'b0000, zero_cnt=0, out=0, out_valid=0.
- RST asserted mid-operation clears all outputs immediately, without waiting for a clock.
- A request in flight at reset is discarded; out_valid stays 0.
- The first edge after RST deasserts behaves normally.
- Requests are independent of captures; any overlap is resolved by BYPASS as described in Operation.

## Structure
Shared package flag_pkg holds:
- Flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- Condition-code constants COND_ALWAYS … COND_V (3-bit).
- Typedef for the 4-bit flag vector.

One sub-module, flag_cond_mux: combinational, takes 4-bit flags and cond_sel, returns 1 bit. It is reused later by the controller's branch predictor. Flag register, counter and output register live in flag_unit.

## Test plan
1. **Reset:** RST=1 asynchronously mid-cycle with prior state flags=4'b1111, zero_cnt=5 → flags=0, zero_cnt=0, out=0, out_valid=0 before the next edge.
2. **Capture and evaluate:** DATA_W=16. Capture alu_result=16'h0000, carry=1, ovf=0 → flags=4'b0101, zero_cnt=1. Then OUT_EN with cond_sel=1 → out=1, out_valid pulse of exactly 1 cycle. Then cond_sel=6 → out=0.
3. **Sticky overflow:** STICKY_V=1. Capture ovf=1, then ovf=0 → V stays 1. CLR alone → flags=0. Simultaneous CLR+ALU_EN with ovf=0, result=16'h8000 → flags=4'b0010.
4. **Bypass:** flags Z=0. Same-cycle ALU_EN with result 0 and OUT_EN cond_sel=1 → BYPASS=1 gives out=1; BYPASS=0 gives out=0.
5. **Counter saturation:** ZCNT_W=2. 5 consecutive zero captures → zero_cnt goes 1,2,3,3,3. Then CLR+zero capture → zero_cnt=1.
6. **Back-to-back requests:** 3 consecutive OUT_EN cycles with cond_sel 0,2,3 on flags 4'b0010 → out 1,1,1 with out_valid high 3 cycles, then low.
